fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage for the pipelined RV32I core. It owns the program counter, drives the word address to the instruction memory, and captures the returned instruction into the IF/ID pipeline register that feeds decode, the control unit and the immediate generator. It accepts stall requests from the hazard unit and PC redirects from the EX-stage branch/jump resolution. It stops fetching on ECALL/EBREAK, and faults on a misaligned redirect target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned)
IMEM_AW, 8, instruction-memory word-address width
NOP_INST, 32'h0000_0013, bubble instruction (ADDI x0,x0,0) inserted on flush/halt/fault

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID contents
redirect  input  1  EX stage: taken branch / JAL / JALR, load redirect_target
redirect_target  input  32  next PC on redirect
imem_addr  output  IMEM_AW  word address to instruction memory = pc[IMEM_AW+1:2]
imem_data  input  32  instruction word, combinational read of imem_addr
pc_out  output  32  current fetch PC
ifid_inst  output  32  IF/ID instruction
ifid_pc  output  32  IF/ID PC of that instruction
ifid_pc4  output  32  IF/ID PC+4 (link value for JAL/JALR)
ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble)
halted  output  1  high while state = HALT
fault  output  1  high while state = FAULT

Behaviour:
- State machine states: RUN, HALT, FAULT. All registers synchronous. There are no combinational paths from redirect or stall to the outputs except imem_addr, which is derived from pc.
- Reset (rst=1 at edge) overrides everything and sets:
  - pc=RESET_PC, state=RUN
  - ifid_inst=NOP_INST, ifid_pc=0, ifid_pc4=0, ifid_valid=0
  - halted=0, fault=0
- Per-cycle priority is rst > redirect > stall > normal advance.
- RUN, normal (no redirect, no stall):
  - pc <= pc+4, with modulo-2^32 wrap (32'hFFFF_FFFC -> 0)
  - ifid_inst <= imem_data, ifid_pc <= pc, ifid_pc4 <= pc+4, ifid_valid <= 1
  - Fetch-to-IF/ID latency is 1 cycle.
- RUN, imem_data equals ECALL (32'h0000_0073) or EBREAK (32'h0010_0073) under normal advance:
  - The instruction is latched into IF/ID normally.
  - pc holds (does not increment); state <= HALT.
- RUN, stall=1 without redirect: pc and all ifid_* hold. Halt detection is suppressed.
- Redirect (in RUN or HALT), stall ignored:
  - Aligned target (redirect_target[1:0]==0): pc <= redirect_target, state <= RUN.
  - Misaligned target: pc <= redirect_target, state <= FAULT.
  - In both cases IF/ID is flushed: ifid_inst <= NOP_INST, ifid_valid <= 0, ifid_pc/ifid_pc4 <= 0.
  - The wrong-path instruction in IF is discarded.
- HALT:
  - pc holds.
  - Each non-stalled cycle loads a bubble (NOP_INST, valid=0).
  - stall holds IF/ID.
  - Exit only via redirect (an older branch squashed the ECALL) or rst.
- FAULT:
  - pc holds; IF/ID is held at bubble (valid=0).
  - redirect and stall are ignored; exit only via rst.
- halted = (state==HALT); fault = (state==FAULT). Both are registered and asserted the cycle after the causing edge.
- ifid_pc4 is computed from the same pc as ifid_pc; it is never re-derived after redirect.

Test Plan:
- Reset then 4 free-running cycles, imem returning 0x00A00093, 0x00100113, ... -> pc_out 0,4,8,12,16; ifid_pc lags by one cycle; ifid_valid=1 from cycle 2; ifid_pc4=ifid_pc+4.
- stall=1 for 2 cycles at pc=8 -> pc_out stays 8 and ifid_* frozen for both cycles; on release, advance resumes with no duplicate or lost instruction.
- redirect=1, target=0x40, together with stall=1 at pc=0x10 -> next cycle pc_out=0x40, ifid_inst=0x00000013, ifid_valid=0; following cycle ifid_pc=0x40.
- imem returns 0x00000073 at pc=0x20 -> ifid_inst=0x73, valid=1; pc_out stays 0x20; halted=1; subsequent ifid_valid=0. Then redirect to 0x24 -> halted=0, pc_out=0x24, fetch resumes.
- redirect target 0x42 -> fault=1, pc_out=0x42, ifid_valid=0; a later redirect to 0x80 is ignored; rst clears fault and gives pc_out=RESET_PC.
- Start with pc=0xFFFF_FFFC (RESET_PC override) and advance -> pc_out=0x0000_0000, ifid_pc4=0x0000_0000; rst asserted mid-stall -> all outputs return to reset values on that edge.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage of the pipelined RV32I core. Owns the program
//   counter, addresses the instruction memory, and captures the returned word
//   into the IF/ID register. Stops fetching on ECALL/EBREAK (HALT) and locks up
//   on a misaligned redirect target (FAULT) until reset.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   stall               hold PC and IF/ID
//   redirect            load redirect_target into PC, flush IF/ID
//   redirect_target     next PC on redirect
//   imem_addr           word address to instruction memory (pc[IMEM_AW+1:2])
//   imem_data           instruction word read combinationally at imem_addr
//   pc_out              current fetch PC
//   ifid_inst/pc/pc4    IF/ID instruction, its PC and PC+4 link value
//   ifid_valid          IF/ID holds a real instruction (0 = bubble)
//   halted, fault       state == HALT / state == FAULT
//
// state | meaning
// RUN   | fetching sequentially
// HALT  | ECALL/EBREAK fetched; PC frozen, bubbles issued until redirect
// FAULT | misaligned redirect target; everything frozen until reset

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 8,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        pc_out,
  output logic [31:0]        ifid_inst,
  output logic [31:0]        ifid_pc,
  output logic [31:0]        ifid_pc4,
  output logic               ifid_valid,
  output logic               halted,
  output logic               fault
);

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] inst_q, inst_nxt;
  logic [31:0] ipc_q, ipc_nxt;
  logic [31:0] ipc4_q, ipc4_nxt;
  logic        valid_q, valid_nxt;

  logic [31:0] pc_plus4;
  logic        is_sys;

  assign pc_plus4 = pc + 32'd4;
  assign is_sys   = (imem_data == ECALL) || (imem_data == EBREAK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      pc      <= RESET_PC;
      inst_q  <= NOP_INST;
      ipc_q   <= 32'd0;
      ipc4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      inst_q  <= inst_nxt;
      ipc_q   <= ipc_nxt;
      ipc4_q  <= ipc4_nxt;
      valid_q <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    inst_nxt  = inst_q;
    ipc_nxt   = ipc_q;
    ipc4_nxt  = ipc4_q;
    valid_nxt = valid_q;

    case (state)
      RUN, HALT: begin
        if (redirect) begin
          // Redirect beats stall; the wrong-path word in IF is dropped.
          pc_nxt    = redirect_target;
          state_nxt = (redirect_target[1:0] == 2'b00) ? RUN : FAULT;
          inst_nxt  = NOP_INST;
          ipc_nxt   = 32'd0;
          ipc4_nxt  = 32'd0;
          valid_nxt = 1'b0;
        end else if (!stall) begin
          if (state == HALT) begin
            inst_nxt  = NOP_INST;
            ipc_nxt   = 32'd0;
            ipc4_nxt  = 32'd0;
            valid_nxt = 1'b0;
          end else begin
            inst_nxt  = imem_data;
            ipc_nxt   = pc;
            ipc4_nxt  = pc_plus4;
            valid_nxt = 1'b1;
            // ECALL/EBREAK still goes down the pipe, but fetch stops behind it.
            if (is_sys) state_nxt = HALT;
            else        pc_nxt    = pc_plus4;
          end
        end
      end
      default: begin
        state_nxt = FAULT;
        inst_nxt  = NOP_INST;
        ipc_nxt   = 32'd0;
        ipc4_nxt  = 32'd0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  assign imem_addr  = pc[IMEM_AW+1:2];
  assign pc_out     = pc;
  assign ifid_inst  = inst_q;
  assign ifid_pc    = ipc_q;
  assign ifid_pc4   = ipc4_q;
  assign ifid_valid = valid_q;
  assign halted     = (state == HALT);
  assign fault      = (state == FAULT);

endmodule
